// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM/owner types and limits for the RAM port-A arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;
    typedef enum logic {OWN_M0, OWN_M1} arb_owner_t;

    localparam int ARB_MAX_READ_LATENCY = 3;
    localparam int ARB_CNT_W            = 8;

endpackage

// File: rtl/ram_arb_rdpipe.sv
// ram_arb_rdpipe: DEPTH-deep {valid, owner} tag line that tracks granted reads until RAM data is due
module ram_arb_rdpipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       in_valid,
    input  arb_owner_t in_owner,
    output logic       out_valid,
    output arb_owner_t out_owner
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] owner;

    // shift each read tag toward the tap; reset squashes everything in flight
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid <= '0;
            owner <= '0;
        end else begin
            valid[0] <= in_valid;
            owner[0] <= in_owner;
            for (int i = 1; i < DEPTH; i++) begin
                valid[i] <= valid[i-1];
                owner[i] <= owner[i-1];
            end
        end
    end

    assign out_valid = valid[DEPTH-1];
    assign out_owner = arb_owner_t'(owner[DEPTH-1]);

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares data-RAM port A between ram_cache (m0) and a second master (m1).
// Default build: idle conflicts go to m0, except the single arbitration right after m0 is
// forced off a capped burst, which goes to m1. Define RAM_ARB_RR_EN for round-robin instead.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int  DATA_WIDTH         = 16,
    parameter int  RAM_REGISTER_COUNT = 1024,
    parameter int  READ_LATENCY       = 1,
    parameter int  MAX_BURST          = 8,
    localparam int ADDR_W             = $clog2(RAM_REGISTER_COUNT)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_W-1:0]     ram_address,
    output logic                  ram_write_m,
    output logic [DATA_WIDTH-1:0] ram_out_m,
    input  logic [DATA_WIDTH-1:0] ram_in_m
);

    localparam logic [ARB_CNT_W-1:0] CAP = ARB_CNT_W'(MAX_BURST);

    if (READ_LATENCY < 1 || READ_LATENCY > ARB_MAX_READ_LATENCY) begin : g_bad_latency
        $error("READ_LATENCY must be 1..%0d", ARB_MAX_READ_LATENCY);
    end

    arb_state_t            state, state_nx;
    logic [ARB_CNT_W-1:0]  burst_cnt, burst_cur, burst_nx;
    logic                  own_active, pick1, any_gnt, win_we, win_lock, other_req, forced;
    arb_owner_t            win;
    logic                  tap_valid;
    arb_owner_t            tap_owner;
    logic [DATA_WIDTH-1:0] hold0, hold1;
`ifdef RAM_ARB_RR_EN
    arb_owner_t            last;
`else
    logic                  force_m1;
`endif

    // grants from requests + registered state, next-state, and port-A mux
    always_comb begin
        own_active = (state == ARB_OWN0 && m0_req) || (state == ARB_OWN1 && m1_req);
`ifdef RAM_ARB_RR_EN
        pick1 = m1_req && (!m0_req || last == OWN_M0);
`else
        pick1 = m1_req && (!m0_req || force_m1);
`endif
        m1_gnt    = resetN && (own_active ? state == ARB_OWN1 : pick1);
        m0_gnt    = resetN && (own_active ? state == ARB_OWN0 : m0_req && !pick1);
        any_gnt   = m0_gnt || m1_gnt;
        win       = m1_gnt ? OWN_M1 : OWN_M0;
        win_we    = m1_gnt ? m1_we : m0_we;
        win_lock  = m1_gnt ? m1_lock : m0_lock;
        other_req = m1_gnt ? m0_req : m1_req;
        burst_cur = !own_active ? ARB_CNT_W'(1) : (burst_cnt >= CAP ? CAP : burst_cnt + 1'b1);
        forced    = any_gnt && win_lock && other_req && burst_cur == CAP;
        state_nx  = (!any_gnt || !win_lock || forced) ? ARB_IDLE : (m1_gnt ? ARB_OWN1 : ARB_OWN0);
        burst_nx  = state_nx == ARB_IDLE ? '0 : burst_cur;
        ram_write_m = any_gnt && win_we;
        ram_address = m1_gnt ? m1_addr : (m0_gnt ? m0_addr : '0);
        ram_out_m   = m1_gnt ? m1_wdata : (m0_gnt ? m0_wdata : '0);
    end

    // FSM state and length of the current locked burst
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= ARB_IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
        end
    end

`ifdef RAM_ARB_RR_EN
    // remember the most recent winner so the next conflict goes to the other side
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            last <= OWN_M1;
        else
            last <= any_gnt ? win : last;
    end
`else
    // after m0 is forced off a capped burst, hand m1 the next arbitration once
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            force_m1 <= 1'b0;
        else
            force_m1 <= (forced && m0_gnt) ? 1'b1 : ((any_gnt && !own_active) ? 1'b0 : force_m1);
    end
`endif

    ram_arb_rdpipe #(.DEPTH(READ_LATENCY)) u_rdpipe (
        .clk       (clk),
        .resetN    (resetN),
        .in_valid  (any_gnt && !win_we),
        .in_owner  (win),
        .out_valid (tap_valid),
        .out_owner (tap_owner)
    );

    assign m0_rvalid = tap_valid && tap_owner == OWN_M0;
    assign m1_rvalid = tap_valid && tap_owner == OWN_M1;
    assign m0_rdata  = m0_rvalid ? ram_in_m : hold0;
    assign m1_rdata  = m1_rvalid ? ram_in_m : hold1;

    // each port keeps showing its last delivered word until its next read returns
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            hold0 <= m0_rdata;
            hold1 <= m1_rdata;
        end
    end

    a_one_grant: assert property (@(posedge clk) disable iff (!resetN) !(m0_gnt && m1_gnt));

endmodule
